// File: rtl/mux_serializer16.sv
// Purpose: parallel-to-serial front end for a 16:1 mux tree; steps the select through one loaded word.
// Latency: handshake at edge T0 drives in_word/s after T0; the first sout_valid appears after T0+1. A word takes 16*HOLD valid cycles.
// Backpressure: accepts a word only in IDLE (load_ready), ignores load_valid while shifting; there is no output stall.
module mux_serializer16 #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int HOLD      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    output logic [15:0] in_word,
    output logic [3:0]  s,
    input  logic        mux_out,
    output logic        sout,
    output logic        sout_valid,
    output logic        first,
    output logic        done,
    output logic        busy
);

    // HOLD sizes the hold counter; anything outside 1..256 is rejected at elaboration
    if (HOLD < 1 || HOLD > 256) begin : g_hold_range
        $error("mux_serializer16: HOLD must be in 1..256");
    end

    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [3:0]    S_START   = MSB_FIRST ? 4'd15 : 4'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [3:0]    s_nxt;
    logic [15:0]   in_word_nxt;
    logic          first_nxt;
    logic          done_nxt;

    assign load_ready = (state == IDLE);
    assign busy       = (state == SHIFT);

    // Output markers are decoded from the current counters and registered with the mux capture
    assign first_nxt = (state == SHIFT) && (bit_cnt == 4'd0) && (hold_cnt == '0);
    assign done_nxt  = (state == SHIFT) && (bit_cnt == 4'd15) && (hold_cnt == HOLD_LAST);

    // Next-state: load on handshake, then walk hold_cnt inside bit_cnt; s never wraps
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        bit_cnt_nxt  = bit_cnt;
        s_nxt        = s;
        in_word_nxt  = in_word;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    in_word_nxt  = load_data;
                    s_nxt        = S_START;
                    hold_cnt_nxt = '0;
                    bit_cnt_nxt  = 4'd0;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end else if (bit_cnt != 4'd15) begin
                    hold_cnt_nxt = '0;
                    bit_cnt_nxt  = bit_cnt + 4'd1;
                    s_nxt        = MSB_FIRST ? (s - 4'd1) : (s + 4'd1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; reset discards any word in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            bit_cnt  <= 4'd0;
            s        <= 4'd0;
            in_word  <= 16'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            s        <= s_nxt;
            in_word  <= in_word_nxt;
        end
    end

    // One-stage output pipeline capturing the mux result and its framing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            first      <= 1'b0;
            done       <= 1'b0;
        end else begin
            sout       <= mux_out;
            sout_valid <= (state == SHIFT);
            first      <= first_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mux_serializer16.sv
// Purpose: scoreboard bench for three serializer builds (HOLD=1 LSB-first, HOLD=1 MSB-first, HOLD=3 LSB-first).
// Latency: expected bit streams are queued at handshake and popped whenever sout_valid is seen.
// Backpressure: drivers wait on load_ready with a bounded cycle budget.
module tb_mux_serializer16;

    typedef struct {
        logic b;
        logic f;
        logic d;
        int   fc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        lv      [3];
    logic [15:0] ld      [3];
    logic        lr      [3];
    logic [15:0] in_word [3];
    logic [3:0]  s       [3];
    logic        mux_out [3];
    logic        sout    [3];
    logic        sv      [3];
    logic        first   [3];
    logic        done    [3];
    logic        busy    [3];

    int   cyc;
    int   tests;
    int   fails;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    mux_serializer16 #(.MSB_FIRST(1'b0), .HOLD(1)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
        .in_word(in_word[0]), .s(s[0]), .mux_out(mux_out[0]), .sout(sout[0]),
        .sout_valid(sv[0]), .first(first[0]), .done(done[0]), .busy(busy[0]));
    mux_serializer16 #(.MSB_FIRST(1'b1), .HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
        .in_word(in_word[1]), .s(s[1]), .mux_out(mux_out[1]), .sout(sout[1]),
        .sout_valid(sv[1]), .first(first[1]), .done(done[1]), .busy(busy[1]));
    mux_serializer16 #(.MSB_FIRST(1'b0), .HOLD(3)) u2 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2]),
        .in_word(in_word[2]), .s(s[2]), .mux_out(mux_out[2]), .sout(sout[2]),
        .sout_valid(sv[2]), .first(first[2]), .done(done[2]), .busy(busy[2]));

    // Behavioural 16:1 mux tree
    for (genvar k = 0; k < 3; k++) begin : g_mux
        assign mux_out[k] = in_word[k][s[k]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hold_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Reference: each bit index in transmit order repeated HOLD times
    task automatic model_word(input int k, input logic [15:0] w, input int fc);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < hold_of(k); j++) begin
                e.b  = msb_of(k) ? w[15 - i] : w[i];
                e.f  = (i == 0) && (j == 0);
                e.d  = (i == 15) && (j == hold_of(k) - 1);
                e.fc = fc;
                push_exp(k, e);
            end
        end
    endtask

    task automatic send(input int k, input logic [15:0] w, output int hs);
        int t;
        t  = 0;
        hs = -1;
        @(negedge clk);
        lv[k] = 1'b1;
        ld[k] = w;
        while (!lr[k] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!lr[k]) begin
            fails++;
            $display("FAIL send_timeout: inst %0d load_ready stayed %0b, required 1", k, lr[k]);
            lv[k] = 1'b0;
        end else begin
            hs = cyc + 1;
            model_word(k, w, cyc + 2);
            @(posedge clk);
            #1;
            lv[k] = 1'b0;
            chk($sformatf("busy_after_hs%0d", k), {31'd0, busy[k]}, 32'd1);
            chk($sformatf("ready_after_hs%0d", k), {31'd0, lr[k]}, 32'd0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_q0", qsize(0), 0);
        chk("drain_q1", qsize(1), 0);
        chk("drain_q2", qsize(2), 0);
        @(negedge clk);
    endtask

    task automatic check_reset(input int k);
        chk($sformatf("rst_sout%0d", k),  {31'd0, sout[k]},  32'd0);
        chk($sformatf("rst_valid%0d", k), {31'd0, sv[k]},    32'd0);
        chk($sformatf("rst_first%0d", k), {31'd0, first[k]}, 32'd0);
        chk($sformatf("rst_done%0d", k),  {31'd0, done[k]},  32'd0);
        chk($sformatf("rst_busy%0d", k),  {31'd0, busy[k]},  32'd0);
        chk($sformatf("rst_ready%0d", k), {31'd0, lr[k]},    32'd1);
        chk($sformatf("rst_s%0d", k),     {28'd0, s[k]},     32'd0);
        chk($sformatf("rst_word%0d", k),  {16'd0, in_word[k]}, 32'd0);
    endtask

    // Monitor: compare every presented serial bit against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    if (sv[k]) begin
                        if (qsize(k) == 0) begin
                            fails++;
                            $display("FAIL unexpected_valid: inst %0d sout_valid=1 with nothing expected", k);
                        end else begin
                            pop_exp(k, e);
                            chk($sformatf("sout%0d", k),  {31'd0, sout[k]},  {31'd0, e.b});
                            chk($sformatf("first%0d", k), {31'd0, first[k]}, {31'd0, e.f});
                            chk($sformatf("done%0d", k),  {31'd0, done[k]},  {31'd0, e.d});
                            if (e.f) chk($sformatf("first_cycle%0d", k), cyc, e.fc);
                            if (e.d) chk($sformatf("ready_in_done%0d", k), {31'd0, lr[k]}, 32'd1);
                        end
                    end else begin
                        if (first[k] || done[k]) begin
                            fails++;
                            $display("FAIL marker_without_valid: inst %0d first=%0b done=%0b, required 0", k, first[k], done[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int hs_a, hs_b, t;
        cyc   = 0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0;
            ld[k] = 16'd0;
        end

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset(k);

        // Directed words from the test plan
        send(0, 16'hA5C3, hs_a);
        drain();
        chk("s_end_lsb", {28'd0, s[0]}, 32'd15);
        send(1, 16'h8001, hs_a);
        drain();
        chk("s_end_msb", {28'd0, s[1]}, 32'd0);
        send(2, 16'h0002, hs_a);
        drain();

        // Back-to-back: second handshake lands in the done cycle
        send(0, 16'hFFFF, hs_a);
        send(0, 16'h0000, hs_b);
        chk("b2b_period_h1", hs_b - hs_a, 17);
        send(2, 16'hFFFF, hs_a);
        send(2, 16'h0000, hs_b);
        chk("b2b_period_h3", hs_b - hs_a, 49);
        drain();

        // Mid-word reset at bit 7 of 16'h1234
        send(0, 16'h1234, hs_a);
        t = 0;
        while (qsize(0) > 9 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reached_bit7", qsize(0), 9);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        q0.delete();
        repeat (2) @(negedge clk);
        check_reset(0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_valid_after_rst", {31'd0, sv[0]}, 32'd0);
        send(0, 16'h00FF, hs_a);
        drain();

        // Randomized concurrent traffic with random idle gaps
        fork
            begin
                int h;
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(0, 16'($urandom), h);
                end
            end
            begin
                int h;
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(1, 16'($urandom), h);
                end
            end
            begin
                int h;
                for (int i = 0; i < 4; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(2, 16'($urandom), h);
                end
            end
        join
        drain();
        for (int k = 0; k < 3; k++) chk($sformatf("idle_end%0d", k), {31'd0, busy[k]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
